// File: rtl/tw_core.sv
// tw_core: parametrised TD4-style CPU with FETCH/EXEC sequencing over a req/ack
// instruction bus, a carry flag, an output register and a small return stack.
module tw_core #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] iaddr,
  output logic              ireq,
  input  logic              iack,
  input  logic [DATA_W+3:0] idata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              halted,
  output logic              fault
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_ADD_AI = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_BI = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_CALL   = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_RET    = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_ADD_AB = 4'b1100;
  localparam logic [3:0] OP_HALT   = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              c;
  logic [SP_W-1:0]   sp;
  logic [DATA_W+3:0] ir;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] imm_addr;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              can_push;
  logic              can_pop;
  logic [DATA_W:0]   sum_ai;
  logic [DATA_W:0]   sum_bi;
  logic [DATA_W:0]   sum_ab;

  function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  assign op       = ir[DATA_W+3:DATA_W];
  assign imm      = ir[DATA_W-1:0];
  assign pc_inc   = pc + ADDR_W'(1);
  assign imm_addr = to_addr(imm);
  assign can_push = (sp < SP_W'(STACK_DEPTH));
  assign can_pop  = (sp != '0);
  // sp never exceeds STACK_DEPTH, so its low bits address the stack directly
  assign push_idx = sp[IDX_W-1:0];
  assign pop_idx  = sp[IDX_W-1:0] - IDX_W'(1);
  assign sum_ai   = add_carry(a, imm);
  assign sum_bi   = add_carry(b, imm);
  assign sum_ab   = add_carry(a, b);

  assign ireq  = (state == FETCH);
  assign iaddr = pc;

  always_ff @(posedge clock) begin
    if (state == FETCH && iack) ir <= idata;
  end

  always_ff @(posedge clock) begin
    if (state == EXEC && op == OP_CALL && can_push) stack[push_idx] <= pc_inc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= 1'b0;
      sp        <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        FETCH: if (iack) state <= EXEC;
        EXEC: begin
          state <= FETCH;
          pc    <= pc_inc;
          case (op)
            OP_ADD_AI: {c, a} <= sum_ai;
            OP_MOV_AB: a <= b;
            OP_IN_A:   a <= in_port;
            OP_MOV_AI: a <= imm;
            OP_MOV_BA: b <= a;
            OP_ADD_BI: {c, b} <= sum_bi;
            OP_IN_B:   b <= in_port;
            OP_MOV_BI: b <= imm;
            OP_CALL: begin
              if (can_push) begin
                sp <= sp + SP_W'(1);
                pc <= imm_addr;
              end else begin
                pc     <= pc;
                fault  <= 1'b1;
                halted <= 1'b1;
                state  <= HALT;
              end
            end
            OP_OUT_B: begin
              out_port  <= b;
              out_valid <= 1'b1;
            end
            OP_RET: begin
              if (can_pop) begin
                sp <= sp - SP_W'(1);
                pc <= stack[pop_idx];
              end else begin
                pc     <= pc;
                fault  <= 1'b1;
                halted <= 1'b1;
                state  <= HALT;
              end
            end
            OP_OUT_I: begin
              out_port  <= imm;
              out_valid <= 1'b1;
            end
            OP_ADD_AB: {c, a} <= sum_ab;
            OP_HALT: begin
              pc     <= pc;
              halted <= 1'b1;
              state  <= HALT;
            end
            OP_JNC: if (!c) pc <= imm_addr;
            OP_JMP: pc <= imm_addr;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tw_core.sv
// Bench for tw_core: directed scenarios plus random programs checked against an
// instruction-level reference model running from the same ROM image.
module tb_tw_core;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int SD = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] iaddr;
  logic          ireq;
  logic          iack;
  logic [7:0]    idata;
  logic [DW-1:0] in_port = '0;
  logic [DW-1:0] out_port;
  logic          out_valid;
  logic          halted;
  logic          fault;

  logic [7:0] rom [16];
  int   checks = 0;
  int   errors = 0;
  int   wait_n = 0;
  logic ack_en = 1'b1;
  int   wcnt   = 0;

  int m_pc, m_a, m_b, m_c, m_out, m_ov, m_halt, m_fault;
  int m_stack[$];

  assign idata = rom[iaddr];
  assign iack  = ack_en && ireq && (wcnt >= wait_n);

  always @(posedge clock) begin
    if (!reset || !ireq || iack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always #5 clock = ~clock;

  tw_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clock(clock), .reset(reset), .iaddr(iaddr), .ireq(ireq), .iack(iack),
    .idata(idata), .in_port(in_port), .out_port(out_port), .out_valid(out_valid),
    .halted(halted), .fault(fault)
  );

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_ov = 0; m_halt = 0; m_fault = 0;
    m_stack.delete();
  endtask

  task automatic model_exec(input int ins, input int inp);
    int op, imm, npc, s;
    m_ov = 0;
    if (m_halt != 0) return;
    op  = (ins >> 4) & 15;
    imm = ins & 15;
    npc = (m_pc + 1) % 16;
    case (op)
      0:  begin s = m_a + imm; m_a = s % 16; m_c = s / 16; end
      1:  m_a = m_b;
      2:  m_a = inp;
      3:  m_a = imm;
      4:  m_b = m_a;
      5:  begin s = m_b + imm; m_b = s % 16; m_c = s / 16; end
      6:  m_b = inp;
      7:  m_b = imm;
      8:  if (m_stack.size() < SD) begin m_stack.push_back(npc); npc = imm; end
          else begin m_fault = 1; m_halt = 1; npc = m_pc; end
      9:  begin m_out = m_b; m_ov = 1; end
      10: if (m_stack.size() > 0) npc = m_stack.pop_back();
          else begin m_fault = 1; m_halt = 1; npc = m_pc; end
      11: begin m_out = imm; m_ov = 1; end
      12: begin s = m_a + m_b; m_a = s % 16; m_c = s / 16; end
      13: begin m_halt = 1; npc = m_pc; end
      14: if (m_c == 0) npc = imm;
      default: npc = imm;
    endcase
    m_pc = npc;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic step();
    repeat (wait_n + 2) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h30 | 8'(i);
    wait_n = 0; ack_en = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({dut.pc, dut.a, dut.b, dut.c, dut.sp} !== '0) begin
      errors++; $display("FAIL reset_regs got pc=%0d a=%0d b=%0d c=%0d sp=%0d want all 0",
                         dut.pc, dut.a, dut.b, dut.c, dut.sp);
    end
    checks++;
    if ({out_port, out_valid, halted, fault} !== '0) begin
      errors++; $display("FAIL reset_outs got out=%0d ov=%0b h=%0b f=%0b want 0",
                         out_port, out_valid, halted, fault);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ireq !== (k % 2 == 0)) begin
        errors++; $display("FAIL fetch_ireq k=%0d got %b want %0b", k, ireq, (k % 2 == 0));
      end
      if (k % 2 == 0) begin
        checks++;
        if (iaddr !== AW'(k / 2)) begin
          errors++; $display("FAIL fetch_iaddr k=%0d got %0d want %0d", k, iaddr, k / 2);
        end
      end
      @(posedge clock);
      @(negedge clock);
    end
    checks++;
    if (dut.a !== 4'd2) begin
      errors++; $display("FAIL fetch_exec_a got %0d want 2", dut.a);
    end
  endtask

  task automatic test_wait_states();
    fill_rom(8'h30);
    rom[0] = 8'h35; rom[1] = 8'h72; rom[2] = 8'h0C;
    wait_n = 3; ack_en = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if ({ireq, iaddr, dut.a} !== {1'b1, 4'(k), 4'(m_a)}) begin
          errors++; $display("FAIL wait_hold k=%0d j=%0d got ireq=%b iaddr=%0d a=%0d want 1 %0d %0d",
                             k, j, ireq, iaddr, dut.a, k, m_a);
        end
        @(posedge clock);
        @(negedge clock);
      end
      model_exec(rom[m_pc], in_port);
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({dut.pc, dut.a, dut.b} !== {4'(m_pc), 4'(m_a), 4'(m_b)}) begin
        errors++; $display("FAIL wait_exec k=%0d got pc=%0d a=%0d b=%0d want %0d %0d %0d",
                           k, dut.pc, dut.a, dut.b, m_pc, m_a, m_b);
      end
    end
    wait_n = 0;
  endtask

  task automatic test_carry_jnc();
    fill_rom(8'h30);
    rom[0] = 8'h39; rom[1] = 8'h08; rom[2] = 8'hE0; rom[3] = 8'h01; rom[4] = 8'hE0;
    do_reset();
    step(); step();
    checks++;
    if ({dut.a, dut.c} !== {4'd1, 1'b1}) begin
      errors++; $display("FAIL carry_set got a=%0d c=%0b want a=1 c=1", dut.a, dut.c);
    end
    step();
    checks++;
    if (dut.pc !== 4'd3) begin
      errors++; $display("FAIL jnc_not_taken got pc=%0d want 3", dut.pc);
    end
    step();
    checks++;
    if ({dut.a, dut.c} !== {4'd2, 1'b0}) begin
      errors++; $display("FAIL carry_clear got a=%0d c=%0b want a=2 c=0", dut.a, dut.c);
    end
    step();
    checks++;
    if (dut.pc !== 4'd0) begin
      errors++; $display("FAIL jnc_taken got pc=%0d want 0", dut.pc);
    end
  endtask

  task automatic test_io();
    fill_rom(8'h30);
    rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hBC;
    in_port = 4'd5;
    do_reset();
    step();
    checks++;
    if (dut.b !== 4'd5) begin
      errors++; $display("FAIL in_b got %0d want 5", dut.b);
    end
    step();
    checks++;
    if ({out_port, out_valid} !== {4'd5, 1'b1}) begin
      errors++; $display("FAIL out_b got out=%0d ov=%b want 5 1", out_port, out_valid);
    end
    @(posedge clock); @(negedge clock);
    checks++;
    if ({out_port, out_valid} !== {4'd5, 1'b0}) begin
      errors++; $display("FAIL out_pulse got out=%0d ov=%b want 5 0", out_port, out_valid);
    end
    @(posedge clock); @(negedge clock);
    checks++;
    if ({out_port, out_valid} !== {4'd12, 1'b1}) begin
      errors++; $display("FAIL out_imm got out=%0d ov=%b want 12 1", out_port, out_valid);
    end
  endtask

  task automatic test_stack();
    fill_rom(8'h30);
    rom[0] = 8'h84; rom[4] = 8'h88; rom[8] = 8'h8C;
    do_reset();
    step();
    checks++;
    if ({dut.pc, dut.sp} !== {4'd4, 2'd1}) begin
      errors++; $display("FAIL call1 got pc=%0d sp=%0d want 4 1", dut.pc, dut.sp);
    end
    step();
    checks++;
    if ({dut.pc, dut.sp} !== {4'd8, 2'd2}) begin
      errors++; $display("FAIL call2 got pc=%0d sp=%0d want 8 2", dut.pc, dut.sp);
    end
    step();
    checks++;
    if ({fault, halted, dut.pc, dut.sp} !== {1'b1, 1'b1, 4'd8, 2'd2}) begin
      errors++; $display("FAIL call_overflow got f=%b h=%b pc=%0d sp=%0d want 1 1 8 2",
                         fault, halted, dut.pc, dut.sp);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (ireq !== 1'b0) begin
      errors++; $display("FAIL halt_ireq got %b want 0", ireq);
    end
    fill_rom(8'h30);
    rom[0] = 8'h85; rom[5] = 8'hA0; rom[1] = 8'hA0;
    do_reset();
    step();
    checks++;
    if ({dut.pc, dut.sp} !== {4'd5, 2'd1}) begin
      errors++; $display("FAIL call_ret got pc=%0d sp=%0d want 5 1", dut.pc, dut.sp);
    end
    step();
    checks++;
    if ({dut.pc, dut.sp} !== {4'd1, 2'd0}) begin
      errors++; $display("FAIL ret got pc=%0d sp=%0d want 1 0", dut.pc, dut.sp);
    end
    step();
    checks++;
    if ({fault, halted, dut.pc, ireq} !== {1'b1, 1'b1, 4'd1, 1'b0}) begin
      errors++; $display("FAIL ret_underflow got f=%b h=%b pc=%0d ireq=%b want 1 1 1 0",
                         fault, halted, dut.pc, ireq);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({halted, fault, dut.pc} !== {1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL areset_halted got h=%b f=%b pc=%0d want 0 0 0", halted, fault, dut.pc);
    end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    fill_rom(8'h30);
    rom[0] = 8'hB7; rom[1] = 8'h33;
    step(); step();
    ack_en = 1'b0;
    @(posedge clock); @(negedge clock);
    checks++;
    if ({ireq, out_port, dut.pc} !== {1'b1, 4'd7, 4'd2}) begin
      errors++; $display("FAIL stall_pre got ireq=%b out=%0d pc=%0d want 1 7 2", ireq, out_port, dut.pc);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dut.pc, out_port, dut.a, halted, fault, ireq} !== {4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL areset_fetch got pc=%0d out=%0d a=%0d h=%b f=%b ireq=%b want 0 0 0 0 0 1",
                         dut.pc, out_port, dut.a, halted, fault, ireq);
    end
    @(negedge clock);
    reset = 1'b1;
    ack_en = 1'b1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      wait_n = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) begin
        rom[i] = 8'($urandom_range(0, 255));
        if (rom[i][7:4] == 4'hD && $urandom_range(0, 3) != 0) rom[i] = rom[i] ^ 8'h10;
      end
      do_reset();
      for (int s = 0; s < 30; s++) begin
        in_port = 4'($urandom_range(0, 15));
        model_exec(rom[m_pc], in_port);
        step();
        checks++;
        if (dut.pc !== 4'(m_pc)) begin
          errors++; $display("FAIL rnd_pc r=%0d s=%0d got %0d want %0d", r, s, dut.pc, m_pc);
        end
        checks++;
        if ({dut.a, dut.b, dut.c} !== {4'(m_a), 4'(m_b), 1'(m_c)}) begin
          errors++; $display("FAIL rnd_abc r=%0d s=%0d got a=%0d b=%0d c=%0b want %0d %0d %0d",
                             r, s, dut.a, dut.b, dut.c, m_a, m_b, m_c);
        end
        checks++;
        if (dut.sp !== 2'(m_stack.size())) begin
          errors++; $display("FAIL rnd_sp r=%0d s=%0d got %0d want %0d", r, s, dut.sp, m_stack.size());
        end
        checks++;
        if ({out_port, out_valid} !== {4'(m_out), 1'(m_ov)}) begin
          errors++; $display("FAIL rnd_out r=%0d s=%0d got out=%0d ov=%b want %0d %0d",
                             r, s, out_port, out_valid, m_out, m_ov);
        end
        checks++;
        if ({halted, fault} !== {1'(m_halt), 1'(m_fault)}) begin
          errors++; $display("FAIL rnd_flags r=%0d s=%0d got h=%b f=%b want %0d %0d",
                             r, s, halted, fault, m_halt, m_fault);
        end
      end
    end
    wait_n = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_wait_states();
    test_carry_jnc();
    test_io();
    test_stack();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
